// File: rtl/pci_arbiter_rr.sv
// pci_arbiter_rr: central PCI bus arbiter for N_MASTERS REQ#/GNT# pairs.
// Fixed-priority or round-robin selection, optional bus parking, hidden
// arbitration during a transaction, one idle GNT# cycle on every hand-over,
// and revocation of a grant whose master never drives FRAME#.
module pci_arbiter_rr #(
  parameter int N_MASTERS    = 4,
  parameter int MODE         = 1,
  parameter int PARK_EN      = 1,
  parameter int PARK_MASTER  = 0,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_MASTERS-1:0]         req_n,
  input  logic                         frame_n,
  input  logic                         irdy_n,
  output logic [N_MASTERS-1:0]         gnt_n,
  output logic [$clog2(N_MASTERS)-1:0] owner,
  output logic                         owner_valid,
  output logic                         bus_idle
);

  localparam int IW = $clog2(N_MASTERS);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [IW-1:0]        PARK_IDX  = IW'(PARK_MASTER);
  localparam logic [IW-1:0]        LAST_IDX  = IW'(N_MASTERS - 1);
  localparam logic [TW-1:0]        TIMEOUT   = TW'(IDLE_TIMEOUT);
  localparam logic [N_MASTERS-1:0] PARK_GNT  = ~(N_MASTERS'(1) << PARK_MASTER);

  typedef enum logic [1:0] {
    S_IDLE,   // nobody granted (GNT# released or parked)
    S_GNT,    // cur granted, waiting for it to start with FRAME#
    S_BUSY,   // cur has started a transaction
    S_TURN    // one cycle with every GNT# high before a new grant
  } state_t;

  state_t               state, state_next;
  logic [IW-1:0]        cur, cur_next;
  logic [IW-1:0]        pend, pend_next;
  logic [IW-1:0]        last_owner, last_next;
  logic [TW-1:0]        timer, timer_next, timer_inc;
  logic [N_MASTERS-1:0] gnt_n_next;

  logic [N_MASTERS-1:0] req;
  logic [N_MASTERS-1:0] req_others;
  logic                 any_req;
  logic                 any_other;
  logic [IW-1:0]        win_all;
  logic [IW-1:0]        win_other;
  logic                 tx_start;
  logic                 idle_wait;

  // Winner among the active-high requests in req. Fixed mode takes the lowest
  // index; round robin takes the first index above 'after', else wraps to the
  // lowest index overall.
  function automatic logic [IW-1:0] pick(input logic [N_MASTERS-1:0] r,
                                         input logic [IW-1:0]        after);
    logic [IW-1:0] low;
    logic [IW-1:0] high;
    logic          high_found;
    low        = '0;
    high       = '0;
    high_found = 1'b0;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      if (r[i]) low = IW'(i);
      if (r[i] && (i > int'(after))) begin
        high       = IW'(i);
        high_found = 1'b1;
      end
    end
    return ((MODE == 1) && high_found) ? high : low;
  endfunction

  assign req        = ~req_n;
  assign req_others = req & ~(N_MASTERS'(1) << cur);
  assign any_req    = |req;
  assign any_other  = |req_others;
  assign win_all    = pick(req, last_owner);
  assign win_other  = pick(req_others, cur);

  // A transaction starts only on FRAME# asserted after an idle bus cycle, so a
  // previous master still finishing its burst is not mistaken for the grantee.
  assign tx_start  = !frame_n && bus_idle;
  assign idle_wait = bus_idle && frame_n;

  assign owner       = cur;
  assign owner_valid = (state == S_GNT) || (state == S_BUSY);

  // Next-state, grant bookkeeping and the next registered GNT# pattern.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch can be inferred.
    state_next = state;
    cur_next   = cur;
    pend_next  = pend;
    last_next  = last_owner;
    timer_next = timer;
    gnt_n_next = '1;
    timer_inc  = (timer == TIMEOUT) ? timer : timer + TW'(1);

    unique case (state)
      S_IDLE: begin
        if (any_req) begin
          if ((&gnt_n) || ((PARK_EN != 0) && (win_all == PARK_IDX))) begin
            state_next = S_GNT;
            cur_next   = win_all;
            timer_next = '0;
          end else begin
            state_next = S_TURN;
            pend_next  = win_all;
          end
        end
      end
      S_GNT: begin
        if (tx_start) begin
          state_next = S_BUSY;
          last_next  = cur;
          timer_next = '0;
        end else if (req_n[cur]) begin
          state_next = any_other ? S_TURN : S_IDLE;
          pend_next  = win_other;
        end else if (idle_wait) begin
          timer_next = timer_inc;
          if (timer_inc == TIMEOUT) begin
            // Unused grant revoked; the master drops to lowest RR priority.
            last_next  = cur;
            state_next = any_other ? S_TURN : S_IDLE;
            pend_next  = win_other;
          end
        end
      end
      S_BUSY: begin
        if (!any_req) begin
          state_next = S_IDLE;
        end else if (win_all != cur) begin
          state_next = S_TURN;
          pend_next  = win_all;
        end
      end
      S_TURN: begin
        if (!req_n[pend]) begin
          state_next = S_GNT;
          cur_next   = pend;
          timer_next = '0;
        end else if (any_req) begin
          state_next = S_GNT;
          cur_next   = win_all;
          timer_next = '0;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase

    unique case (state_next)
      S_GNT, S_BUSY: gnt_n_next = ~(N_MASTERS'(1) << cur_next);
      S_IDLE: begin
        // Park only from a released or already-parked bus, so moving the
        // grant away from another master still costs one idle GNT# cycle.
        if ((PARK_EN != 0) && !any_req && ((&gnt_n) || (gnt_n == PARK_GNT)))
          gnt_n_next = PARK_GNT;
      end
      default: gnt_n_next = '1;
    endcase
  end

  // State, grant and bus-idle registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state      <= S_IDLE;
      cur        <= '0;
      pend       <= '0;
      last_owner <= LAST_IDX;
      timer      <= '0;
      gnt_n      <= '1;
      bus_idle   <= 1'b1;
    end else begin
      state      <= state_next;
      cur        <= cur_next;
      pend       <= pend_next;
      last_owner <= last_next;
      timer      <= timer_next;
      gnt_n      <= gnt_n_next;
      bus_idle   <= frame_n & irdy_n;
    end
  end

endmodule

// File: tb/tb_pci_arbiter_rr.sv
// tb_pci_arbiter_rr: four arbiter configurations driven by shared REQ#/FRAME#/
// IRDY# stimulus, each compared every cycle against a behavioural model, plus
// directed scenarios with fixed expected GNT# patterns.
module tb_pci_arbiter_rr;

  localparam int NM = 4;
  localparam int NC = 4;
  localparam int CFG_MODE    [NC] = '{1, 0, 1, 0};
  localparam int CFG_PARK_EN [NC] = '{1, 0, 1, 1};
  localparam int CFG_PARK    [NC] = '{0, 0, 2, 3};
  localparam int CFG_TO      [NC] = '{16, 16, 3, 2};

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NM-1:0] req_n = '0;
  logic          frame_n = 1'b1;
  logic          irdy_n = 1'b1;

  logic [NM-1:0] gnt_n_o [NC];
  logic [1:0]    owner_o [NC];
  logic          ov_o    [NC];
  logic          bi_o    [NC];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar c = 0; c < NC; c++) begin : g_dut
    pci_arbiter_rr #(
      .N_MASTERS   (NM),
      .MODE        (CFG_MODE[c]),
      .PARK_EN     (CFG_PARK_EN[c]),
      .PARK_MASTER (CFG_PARK[c]),
      .IDLE_TIMEOUT(CFG_TO[c])
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .req_n      (req_n),
      .frame_n    (frame_n),
      .irdy_n     (irdy_n),
      .gnt_n      (gnt_n_o[c]),
      .owner      (owner_o[c]),
      .owner_valid(ov_o[c]),
      .bus_idle   (bi_o[c])
    );
  end

  // Reference model: who holds GNT#, who the arbiter has chosen, whether that
  // master has started, and whether a one-cycle hand-over gap is in progress.
  typedef struct {
    int grant;      // master whose GNT# line is low, -1 for none
    int holder;     // master currently chosen (granted or on the bus), -1 none
    bit started;    // holder has begun a transaction
    bit gap;        // hand-over cycle in progress
    int next_up;    // master chosen to follow the gap
    int waited;     // idle cycles the holder has left the grant unused
    int last;       // most recent bus owner (round-robin reference)
    bit idle_prev;  // bus idle as seen at the previous edge
  } mdl_t;

  mdl_t mdl [NC];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic mdl_t model_reset();
    mdl_t m;
    m.grant = -1; m.holder = -1; m.started = 0; m.gap = 0;
    m.next_up = 0; m.waited = 0; m.last = NM - 1; m.idle_prev = 1;
    return m;
  endfunction

  function automatic int pick(input int c, input logic [NM-1:0] want, input int after);
    if (CFG_MODE[c] == 0) begin
      for (int i = 0; i < NM; i++) if (want[i]) return i;
      return -1;
    end
    for (int k = 1; k <= NM; k++) if (want[(after + k) % NM]) return (after + k) % NM;
    return -1;
  endfunction

  task automatic model_step(input int c);
    mdl_t m, n;
    logic [NM-1:0] want, others;
    int best, other;
    bit leave;
    m = mdl[c];
    n = m;
    want = ~req_n;
    if (reset) begin
      n = model_reset();
    end else begin
      best = pick(c, want, m.last);
      n.idle_prev = frame_n & irdy_n;
      if (m.gap) begin
        n.gap = 0;
        n.holder = want[m.next_up] ? m.next_up : best;
        n.started = 0; n.waited = 0;
      end else if (m.holder < 0) begin
        if (best >= 0) begin
          if (m.grant < 0 || (CFG_PARK_EN[c] != 0 && best == CFG_PARK[c])) begin
            n.holder = best; n.started = 0; n.waited = 0;
          end else begin
            n.gap = 1; n.next_up = best;
          end
        end
      end else if (m.started) begin
        if (best < 0) n.holder = -1;
        else if (best != m.holder) begin
          n.holder = -1; n.gap = 1; n.next_up = best;
        end
      end else begin
        others = want;
        others[m.holder] = 1'b0;
        other = pick(c, others, m.holder);
        leave = 0;
        if (!frame_n && m.idle_prev) begin
          n.started = 1; n.last = m.holder; n.waited = 0;
        end else if (!want[m.holder]) begin
          leave = 1;
        end else if (m.idle_prev && frame_n) begin
          n.waited = m.waited + 1;
          if (n.waited >= CFG_TO[c]) begin
            leave = 1; n.last = m.holder;
          end
        end
        if (leave) begin
          n.holder = -1;
          if (other >= 0) begin
            n.gap = 1; n.next_up = other;
          end
        end
      end
      if (n.holder >= 0) n.grant = n.holder;
      else if (n.gap || want != 0) n.grant = -1;
      else if (CFG_PARK_EN[c] != 0 && (m.grant < 0 || m.grant == CFG_PARK[c])) n.grant = CFG_PARK[c];
      else n.grant = -1;
    end
    mdl[c] = n;
  endtask

  function automatic logic [NM-1:0] gnt_pattern(input int g);
    logic [NM-1:0] one;
    one = 1;
    return (g < 0) ? '1 : ~(one << g);
  endfunction

  // One clock: advance the model at the edge, compare all outputs mid-cycle.
  task automatic tick();
    @(posedge clk);
    for (int c = 0; c < NC; c++) model_step(c);
    @(negedge clk);
    for (int c = 0; c < NC; c++) begin
      check($sformatf("c%0d gnt_n", c), 32'(gnt_n_o[c]), 32'(gnt_pattern(mdl[c].grant)));
      check($sformatf("c%0d owner_valid", c), 32'(ov_o[c]), 32'(mdl[c].holder >= 0));
      if (mdl[c].holder >= 0)
        check($sformatf("c%0d owner", c), 32'(owner_o[c]), 32'(mdl[c].holder));
      check($sformatf("c%0d bus_idle", c), 32'(bi_o[c]), 32'(mdl[c].idle_prev));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; req_n = '1; frame_n = 1'b1; irdy_n = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int order[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int ones_run, txn, n;
    logic [NM-1:0] g, prev_g;

    for (int c = 0; c < NC; c++) mdl[c] = model_reset();

    // Reset held two cycles with every REQ# asserted.
    reset = 1'b1; req_n = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      tick();
      for (int c = 0; c < NC; c++) begin
        check($sformatf("rst c%0d gnt_n", c), 32'(gnt_n_o[c]), 32'hF);
        check($sformatf("rst c%0d owner_valid", c), 32'(ov_o[c]), 32'h0);
      end
    end
    check("rst owner", 32'(owner_o[0]), 32'h0);

    // Single request without parking, then a one-cycle transaction.
    do_reset();
    req_n = 4'b1110;
    tick();
    check("np grant", 32'(gnt_n_o[1]), 32'hE);
    frame_n = 1'b0; irdy_n = 1'b0;
    tick();
    check("np owner_valid", 32'(ov_o[1]), 32'h1);
    check("np owner", 32'(owner_o[1]), 32'h0);
    req_n = 4'b1111; frame_n = 1'b1; irdy_n = 1'b1;
    tick();
    check("np release", 32'(gnt_n_o[1]), 32'hF);

    // Round robin with all masters requesting; each granted master runs a
    // 3-cycle transaction once the bus has been idle for a cycle.
    do_reset();
    req_n = 4'b0000;
    ones_run = 0; txn = 0; prev_g = '1;
    for (int cyc = 0; cyc < 80 && order.size() < 5; cyc++) begin
      tick();
      g = gnt_n_o[0];
      if (g == 4'hF) begin
        ones_run++;
      end else begin
        if (g != prev_g) begin
          if (order.size() > 0) check("rr turnaround", 32'(ones_run), 32'd1);
          for (int i = 0; i < NM; i++) if (!g[i]) order.push_back(i);
        end
        ones_run = 0;
      end
      prev_g = g;
      if (txn > 0) txn--;
      if (txn == 0 && frame_n && irdy_n && g != 4'hF) txn = 3;
      frame_n = !(txn >= 2);
      irdy_n  = (txn == 0);
    end
    check("rr grant count", 32'(order.size()), 32'd5);
    for (int i = 0; i < 5 && i < order.size(); i++)
      check($sformatf("rr order %0d", i), 32'(order[i]), 32'(exp_order[i]));
    frame_n = 1'b1; irdy_n = 1'b1;

    // Fixed priority: hidden arbitration hands the bus to master 0.
    do_reset();
    req_n = 4'b1001;
    tick();
    check("fp first grant", 32'(gnt_n_o[1]), 32'hD);
    frame_n = 1'b0; irdy_n = 1'b0;
    tick();
    check("fp busy owner", 32'(owner_o[1]), 32'h1);
    req_n = 4'b1000;
    tick();
    check("fp turnaround", 32'(gnt_n_o[1]), 32'hF);
    tick();
    check("fp regrant", 32'(gnt_n_o[1]), 32'hE);
    frame_n = 1'b1; irdy_n = 1'b1;

    // Unused grant: master 2 never drives FRAME#.
    do_reset();
    req_n = 4'b1011;
    tick();
    n = 0;
    while (gnt_n_o[0] == 4'b1011 && n < 40) begin
      n++;
      tick();
    end
    check("timeout length", 32'(n), 32'd16);
    check("timeout revoke", 32'(gnt_n_o[0]), 32'hF);
    tick();
    check("timeout regrant", 32'(gnt_n_o[0]), 32'hB);

    // Parking on master 0.
    do_reset();
    tick();
    tick();
    check("park idle", 32'(gnt_n_o[0]), 32'hE);
    req_n = 4'b1110;
    tick();
    check("park keep", 32'(gnt_n_o[0]), 32'hE);
    check("park owner_valid", 32'(ov_o[0]), 32'h1);
    req_n = 4'b0111;
    tick();
    check("park turnaround", 32'(gnt_n_o[0]), 32'hF);
    tick();
    check("park move", 32'(gnt_n_o[0]), 32'h7);

    // Random traffic: busy bus with occasional resets, then a quiet bus so
    // unused grants time out.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < NM; b++) if ($urandom_range(0, 7) == 0) req_n[b] = ~req_n[b];
      if (i < 2000) begin
        if ($urandom_range(0, 4) == 0) frame_n = ~frame_n;
        if ($urandom_range(0, 4) == 0) irdy_n = ~irdy_n;
      end else begin
        frame_n = 1'b1;
        irdy_n  = 1'b1;
      end
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
